// File: rtl/ibex_mem_arbiter.sv
// Two-requester arbiter (fetch + LSU) onto a single memory port with an
// in-order owner FIFO that steers responses back to the requester that issued them.
module ibex_mem_arbiter #(
  parameter int unsigned OUTSTANDING    = 2,
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,

  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,

  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,

  output logic        err_o
);

  localparam int unsigned CNT_W   = $clog2(OUTSTANDING + 1);
  localparam int unsigned PTR_W   = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned BURST_W = $clog2(DATA_BURST_MAX + 1);

  localparam logic [CNT_W-1:0]   OUT_MAX   = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(OUTSTANDING - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DATA_BURST_MAX);

  typedef enum logic [1:0] {ARB, HOLD_I, HOLD_D} state_e;
  typedef enum logic [1:0] {SEL_NONE, SEL_I, SEL_D} sel_e;

  state_e             state_q, state_d;
  sel_e               sel;
  logic [CNT_W-1:0]   out_cnt_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [BURST_W-1:0] burst_cnt_q;
  logic               err_q;
  logic [OUTSTANDING-1:0] owner_q;  // 0 = instruction, 1 = data

  logic can_issue;
  logic burst_at_max;
  logic push, pop, head_is_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign can_issue    = (out_cnt_q < OUT_MAX);
  assign burst_at_max = (burst_cnt_q == BURST_MAX);

  // NOTE: every signal written here gets a default first so no path leaves a
  // value unassigned -- that is what keeps synthesis from inferring latches.
  always_comb begin
    sel         = SEL_NONE;
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      HOLD_I:  sel = SEL_I;
      HOLD_D:  sel = SEL_D;
      default: begin
        // Data has priority until it has starved a waiting fetch for a full burst.
        if (data_req_i && !(burst_at_max && instr_req_i)) sel = SEL_D;
        else if (instr_req_i)                              sel = SEL_I;
      end
    endcase

    unique case (sel)
      SEL_I: begin
        mem_req_o  = instr_req_i & can_issue;
        mem_addr_o = instr_addr_i;
        mem_be_o   = 4'b1111;
      end
      SEL_D: begin
        mem_req_o   = data_req_i & can_issue;
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end
      default: ;
    endcase

    // An ungranted request locks its owner so its attributes stay on the bus.
    if (mem_req_o) begin
      if (mem_gnt_i)          state_d = ARB;
      else if (sel == SEL_I)  state_d = HOLD_I;
      else                    state_d = HOLD_D;
    end
  end

  assign instr_gnt_o = mem_gnt_i & mem_req_o & (sel == SEL_I);
  assign data_gnt_o  = mem_gnt_i & mem_req_o & (sel == SEL_D);

  assign push         = mem_req_o & mem_gnt_i;
  assign pop          = mem_rvalid_i & (out_cnt_q != '0);
  assign head_is_data = owner_q[rd_ptr_q];

  assign instr_rvalid_o = pop & ~head_is_data;
  assign data_rvalid_o  = pop &  head_is_data;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign err_o          = err_q;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      out_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

      unique case ({push, pop})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: ;
      endcase

      if (instr_gnt_o || !instr_req_i)       burst_cnt_q <= '0;
      else if (data_gnt_o && !burst_at_max)  burst_cnt_q <= burst_cnt_q + 1'b1;

      if (mem_rvalid_i && (out_cnt_q == '0)) err_q <= 1'b1;
    end
  end

  // NOTE: owner storage is deliberately not reset; entries are only read
  // between a push and its pop, and the reset pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) owner_q[wr_ptr_q] <= (sel == SEL_D);
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Randomised bench for ibex_mem_arbiter: a transaction-level reference model predicts
// arbitration per cycle; a response scoreboard checks rvalid steering independently.
module tb_ibex_mem_arbiter;

  localparam int OUTS = 2;
  localparam int DBM  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_be_i;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic        err_o;

  ibex_mem_arbiter #(.OUTSTANDING(OUTS), .DATA_BURST_MAX(DBM)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    bit          dv;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_igrant = 0;

  // Reference model state: who the port is locked to, data grants since the fetch
  // started waiting, and the owners of accepted-but-unanswered transactions in order.
  int   lock  = 0;   // 0 none, 1 instr, 2 data
  int   burst = 0;
  bit   outq[$];     // 0 instr, 1 data
  bit   err_m = 0;

  // Requester-side stimulus, held until granted.
  bit          i_pend = 0, d_pend = 0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_rvalid_i || instr_rvalid_o || data_rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("instr_rvalid", instr_rvalid_o, e.iv);
        check("data_rvalid",  data_rvalid_o,  e.dv);
        check("instr_rdata",  instr_rdata_o,  e.rdata);
        check("data_rdata",   data_rdata_o,   e.rdata);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    i_pend = 0; d_pend = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    lock = 0; burst = 0; outq.delete(); err_m = 0;
    #3;
    check("rst_err",     err_o,     32'd0);
    check("rst_mem_req", mem_req_o, 32'd0);
    check("rst_rvalids", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    #1;
  endtask

  // One clock of stimulus + prediction; entered and left at posedge+1.
  task automatic cycle(input int p_i, input int p_d, input int p_g, input int p_r,
                       input bit force_rv);
    int          sel;
    bit          exp_req, exp_ig, exp_dg;
    logic [31:0] ea, ew;
    logic        ewe;
    logic [3:0]  ebe;
    rsp_t        e;

    if (!i_pend && $urandom_range(99) < p_i) begin
      i_pend = 1; i_addr = $urandom;
    end
    if (!d_pend && $urandom_range(99) < p_d) begin
      d_pend = 1; d_addr = $urandom; d_we = 1'($urandom_range(1));
      d_be = 4'($urandom); d_wdata = $urandom;
    end
    instr_req_i = i_pend; instr_addr_i = i_addr;
    data_req_i = d_pend; data_addr_i = d_addr; data_we_i = d_we;
    data_be_i = d_be; data_wdata_i = d_wdata;
    mem_gnt_i    = ($urandom_range(99) < p_g);
    mem_rvalid_i = force_rv || (outq.size() > 0 && $urandom_range(99) < p_r);
    mem_rdata_i  = $urandom;

    if (lock != 0)                           sel = lock;
    else if (d_pend && !(burst == DBM && i_pend)) sel = 2;
    else if (i_pend)                         sel = 1;
    else                                     sel = 0;

    exp_req = (outq.size() < OUTS) && ((sel == 1 && i_pend) || (sel == 2 && d_pend));
    exp_ig  = exp_req && mem_gnt_i && sel == 1;
    exp_dg  = exp_req && mem_gnt_i && sel == 2;
    ea = '0; ewe = 1'b0; ebe = '0; ew = '0;
    if (sel == 1) begin ea = i_addr; ebe = 4'hF; end
    if (sel == 2) begin ea = d_addr; ewe = d_we; ebe = d_be; ew = d_wdata; end

    if (mem_rvalid_i) begin
      e.rdata = mem_rdata_i;
      e.iv = (outq.size() > 0) && (outq[0] == 1'b0);
      e.dv = (outq.size() > 0) && (outq[0] == 1'b1);
      exp_q.push_back(e);
    end

    #3;
    check("mem_req",   mem_req_o,   exp_req);
    check("mem_addr",  mem_addr_o,  ea);
    check("mem_we",    mem_we_o,    ewe);
    check("mem_be",    mem_be_o,    ebe);
    check("mem_wdata", mem_wdata_o, ew);
    check("instr_gnt", instr_gnt_o, exp_ig);
    check("data_gnt",  data_gnt_o,  exp_dg);
    check("err",       err_o,       err_m);
    if (instr_gnt_o) n_igrant++;

    @(posedge clk); #1;
    if (exp_req) lock = mem_gnt_i ? 0 : sel;
    if (exp_ig || !i_pend)           burst = 0;
    else if (exp_dg && burst < DBM)  burst++;
    if (mem_rvalid_i) begin
      if (outq.size() > 0) void'(outq.pop_front());
      else                 err_m = 1;
    end
    if (exp_ig) begin outq.push_back(1'b0); i_pend = 0; end
    if (exp_dg) begin outq.push_back(1'b1); d_pend = 0; end
  endtask

  initial begin
    rst = 1'b1;
    instr_req_i = 0; instr_addr_i = '0; data_req_i = 0; data_addr_i = '0;
    data_we_i = 0; data_be_i = '0; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    @(posedge clk); #1;
    do_reset();

    // Saturated traffic with an always-ready memory: four data grants, then one fetch.
    n_igrant = 0;
    for (int k = 0; k < 25; k++) cycle(100, 100, 100, 100, 0);
    check("burst_pattern_igrants", n_igrant, 32'd5);

    // No responses: the port must stop requesting once OUTSTANDING are in flight.
    for (int k = 0; k < 6; k++) cycle(100, 100, 100, 0, 0);
    for (int k = 0; k < 6; k++) cycle(0, 0, 100, 100, 0);

    // Slow memory exercises the hold states; mixed rates exercise everything else.
    for (int k = 0; k < 800; k++)  cycle(60, 60, 25, 40, 0);
    for (int k = 0; k < 1200; k++) cycle(50, 50, 70, 60, 0);
    for (int k = 0; k < 10; k++)   cycle(0, 0, 100, 100, 0);

    // Response with nothing outstanding raises a sticky error.
    do_reset();
    cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0);

    // Reset with transactions in flight discards them; late responses are errors.
    do_reset();
    for (int k = 0; k < 10 && outq.size() < OUTS; k++) cycle(80, 80, 100, 0, 0);
    do_reset();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(100, 0, 100, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 100, 100, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
